ram_sp_req_ctrl: RTL and testbench

//  Request-side controller for the 16x8 single-port synchronous-read RAM. Accepts

---
 rtl/ram_sp_req_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ram_sp_req_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_req_ctrl.sv
// Request-side controller for a single-port synchronous-read RAM: valid/ready command
// intake, registered RAM drive, two-stage read pipe into a credit-checked response FIFO.
module ram_sp_req_ctrl #(
   parameter int                 DATA_W    = 8,
   parameter int                 ADDR_W    = 4,
   parameter int                 RSP_DEPTH = 4,
   parameter logic [DATA_W-1:0]  INIT_VAL  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              init_done,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int                PTR_W     = $clog2(RSP_DEPTH);
   localparam int                CNT_W     = $clog2(RSP_DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
   localparam logic [CNT_W:0]    DEPTH_V   = (CNT_W + 1)'(RSP_DEPTH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   init_ptr_reg;
   logic                init_done_reg;
   logic                ram_we_reg;
   logic [ADDR_W-1:0]   ram_addr_reg;
   logic [DATA_W-1:0]   ram_din_reg;
   logic                p1_valid_reg;
   logic                p2_valid_reg;
   logic [ADDR_W-1:0]   p1_addr_reg;
   logic [ADDR_W-1:0]   p2_addr_reg;
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [ADDR_W+DATA_W-1:0] fifo_mem [RSP_DEPTH];

   logic                run;
   logic                flush;
   logic                cmd_fire;
   logic                rd_fire;
   logic                push;
   logic                pop;
   logic [1:0]          rd_inflight;
   logic [CNT_W:0]      credit_used;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign run         = (state_reg == ST_RUN);
   assign flush       = run & clr;
   assign rd_inflight = {1'b0, p1_valid_reg} + {1'b0, p2_valid_reg};
   assign credit_used = {1'b0, count_reg} + {{(CNT_W - 1){1'b0}}, rd_inflight};

   // Reads still in the pipe hold a FIFO slot, so a push can never find the FIFO full.
   assign cmd_ready   = run & ~clr & (credit_used < DEPTH_V);
   assign cmd_fire    = cmd_valid & cmd_ready;
   assign rd_fire     = cmd_fire & ~cmd_we;
   assign rsp_valid   = (count_reg != '0);
   assign push        = p2_valid_reg & ~flush;
   assign pop         = rsp_valid & rsp_ready & ~flush;

   assign init_done   = init_done_reg;
   assign ram_we      = ram_we_reg;
   assign ram_addr    = ram_addr_reg;
   assign ram_din     = ram_din_reg;
   assign {rsp_addr, rsp_data} = fifo_mem[rd_ptr_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_INIT;
         init_ptr_reg  <= '0;
         init_done_reg <= 1'b0;
         ram_we_reg    <= 1'b0;
         ram_addr_reg  <= '0;
         ram_din_reg   <= '0;
         p1_valid_reg  <= 1'b0;
         p2_valid_reg  <= 1'b0;
         p1_addr_reg   <= '0;
         p2_addr_reg   <= '0;
      end else begin
         p1_valid_reg <= rd_fire;
         if (rd_fire) begin
            p1_addr_reg <= cmd_addr;
         end
         p2_valid_reg <= p1_valid_reg & ~flush;
         p2_addr_reg  <= p1_addr_reg;

         case (state_reg)
            ST_INIT: begin
               ram_we_reg   <= 1'b1;
               ram_addr_reg <= init_ptr_reg;
               ram_din_reg  <= INIT_VAL;
               if (init_ptr_reg == LAST_ADDR) begin
                  state_reg     <= ST_RUN;
                  init_done_reg <= 1'b1;
               end else begin
                  init_ptr_reg <= init_ptr_reg + 1'b1;
               end
            end
            ST_RUN: begin
               if (clr) begin
                  ram_we_reg    <= 1'b0;
                  init_ptr_reg  <= '0;
                  init_done_reg <= 1'b0;
                  state_reg     <= ST_INIT;
               end else if (cmd_fire) begin
                  ram_we_reg   <= cmd_we;
                  ram_addr_reg <= cmd_addr;
                  ram_din_reg  <= cmd_wdata;
               end else begin
                  ram_we_reg <= 1'b0;
               end
            end
            default: state_reg <= ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= next_ptr(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ram_dout is sampled exactly two edges after the read was accepted.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {p2_addr_reg, ram_dout};
      end
   end

endmodule

// File: tb/tb_ram_sp_req_ctrl.sv
// Bench for ram_sp_req_ctrl: behavioural RAM, reference memory + expected-response queue,
// vector table, random traffic and hand-built clear/reset sequences.
module tb_ram_sp_req_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 4;
   localparam int NW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          init_done;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] rsp_addr;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   ram_sp_req_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RSP_DEPTH(DEPTH), .INIT_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .init_done(init_done),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // 16x8 single-port RAM with registered read
   logic [DW-1:0] ram_arr [NW];
   always @(posedge clk) begin
      if (ram_we) ram_arr[ram_addr] <= ram_din;
      ram_dout <= ram_arr[ram_addr];
   end

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0h", name, act);
      end
   endtask

   task automatic fail_now(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got timeout/unexpected event, expected handshake", name);
   endtask

   // Reference model: memory contents as commands are accepted, and the responses owed.
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } rsp_t;

   logic [DW-1:0] ref_mem [NW];
   rsp_t          exp_q[$];

   always @(negedge clk) begin
      if (!rst_n || (clr && init_done)) begin
         exp_q.delete();
         for (int i = 0; i < NW; i++) ref_mem[i] = 8'h00;
      end else begin
         if (cmd_ready && !init_done) fail_now("mon_ready_in_init");
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("mon_spurious_rsp");
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check("mon_rsp_data", rsp_data, e.d);
               check("mon_rsp_addr", rsp_addr, e.a);
            end
         end
         if (cmd_valid && cmd_ready) begin
            if (cmd_we) begin
               ref_mem[cmd_addr] = cmd_wdata;
            end else begin
               exp_q.push_back({cmd_addr, ref_mem[cmd_addr]});
               if (exp_q.size() > DEPTH) fail_now("mon_overflow");
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            tick();
            cmd_valid = 1'b0;
            return;
         end
      end
      cmd_valid = 1'b0;
      fail_now("send_cmd_timeout");
   endtask

   task automatic get_rsp(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rsp_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            check({name, "_data"}, rsp_data, d);
            check({name, "_addr"}, rsp_addr, a);
            tick();
            rsp_ready = 1'b0;
            return;
         end
      end
      rsp_ready = 1'b0;
      fail_now({name, "_timeout"});
   endtask

   task automatic check_sweep(input string name);
      for (int k = 0; k < NW; k++) begin
         tick();
         check({name, "_init_we"}, ram_we, 1'b1);
         check({name, "_init_addr"}, ram_addr, k);
         check({name, "_init_din"}, ram_din, 8'h00);
         check({name, "_init_done"}, init_done, (k == NW - 1));
         check({name, "_init_rsp_valid"}, rsp_valid, 1'b0);
      end
      check({name, "_ready_after_init"}, cmd_ready, 1'b1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_ram_we"}, ram_we, 1'b0);
      check({name, "_ram_addr"}, ram_addr, 0);
      check({name, "_ram_din"}, ram_din, 0);
      check({name, "_init_done"}, init_done, 1'b0);
      check({name, "_cmd_ready"}, cmd_ready, 1'b0);
      check({name, "_rsp_valid"}, rsp_valid, 1'b0);
   endtask

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_data;
   } vec_t;

   function automatic logic [DW-1:0] pat(input int i);
      return DW'(i * 7 + 3);
   endfunction

   initial begin
      vec_t vecs[10];
      int   acc;
      int   got;
      int   issued;
      bit   fired;

      vecs[0] = '{1'b1, 4'd0,  8'hA5, 8'h00};
      vecs[1] = '{1'b1, 4'd15, 8'h5A, 8'h00};
      vecs[2] = '{1'b0, 4'd0,  8'h00, 8'hA5};
      vecs[3] = '{1'b0, 4'd15, 8'h00, 8'h5A};
      vecs[4] = '{1'b0, 4'd7,  8'h00, 8'h00};
      vecs[5] = '{1'b1, 4'd7,  8'hFF, 8'h00};
      vecs[6] = '{1'b0, 4'd7,  8'h00, 8'hFF};
      vecs[7] = '{1'b0, 4'd5,  8'h00, 8'h3C};
      vecs[8] = '{1'b1, 4'd5,  8'hC3, 8'h00};
      vecs[9] = '{1'b0, 4'd5,  8'h00, 8'hC3};

      // T1: reset values and the zero-fill sweep
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("t1_reset");
      rst_n = 1'b1;
      check_sweep("t1");
      tick();
      check("t1_idle_we", ram_we, 1'b0);

      // T2: write then immediate read of the same word; 2-cycle latency
      send_cmd(1'b1, 4'd5, 8'h3C);
      check("t2_ram_we", ram_we, 1'b1);
      check("t2_ram_addr", ram_addr, 5);
      check("t2_ram_din", ram_din, 8'h3C);
      send_cmd(1'b0, 4'd5, 8'h00);
      check("t2_lat_n", rsp_valid, 1'b0);
      tick();
      check("t2_lat_n1", rsp_valid, 1'b0);
      tick();
      check("t2_lat_n2", rsp_valid, 1'b1);
      check("t2_data", rsp_data, 8'h3C);
      check("t2_addr", rsp_addr, 5);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t2_popped", rsp_valid, 1'b0);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         send_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata);
         if (!vecs[i].we) get_rsp($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data);
      end

      // T3: credit limit, then in-order streaming of all 16 words
      for (int i = 0; i < NW; i++) send_cmd(1'b1, AW'(i), pat(i));
      rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(acc);
         @(negedge clk);
         if (cmd_ready) acc++;
         tick();
      end
      cmd_addr = AW'(acc);
      check("t3_accepted_stalled", acc, DEPTH);
      check("t3_ready_low", cmd_ready, 1'b0);
      rsp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 200 && got < NW; c++) begin
         @(negedge clk);
         if (cmd_valid && cmd_ready) acc++;
         if (rsp_valid && rsp_ready) begin
            check("t3_order_addr", rsp_addr, got);
            check("t3_order_data", rsp_data, pat(got));
            got++;
         end
         tick();
         cmd_addr = AW'(acc);
         if (acc >= NW) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      check("t3_rsp_count", got, NW);

      // T4: random traffic against the reference model
      issued = 0;
      cmd_valid = 1'b1; cmd_we = 1'($urandom_range(0, 1));
      cmd_addr = AW'($urandom_range(0, NW - 1)); cmd_wdata = DW'($urandom);
      for (int c = 0; c < 5000 && issued < 200; c++) begin
         @(negedge clk);
         fired = cmd_valid && cmd_ready;
         tick();
         rsp_ready = 1'($urandom_range(0, 1));
         if (fired) begin
            issued++;
            cmd_we = 1'($urandom_range(0, 1));
            cmd_addr = AW'($urandom_range(0, NW - 1));
            cmd_wdata = DW'($urandom);
            if (issued >= 200) cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      check("t4_issued", issued, 200);
      rsp_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (exp_q.size() == 0) break;
      end
      tick();
      rsp_ready = 1'b0;
      check("t4_drained", exp_q.size(), 0);
      check("t4_rsp_idle", rsp_valid, 1'b0);

      // T5: clear with 1 response queued and 2 reads in flight
      send_cmd(1'b1, 4'd9, 8'h77);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd5;
      tick();
      cmd_addr = 4'd6;
      tick();
      cmd_addr = 4'd7;
      tick();
      cmd_valid = 1'b0;
      check("t5_fifo_holding", rsp_valid, 1'b1);
      clr = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd3; cmd_wdata = 8'h99;
      #1;
      check("t5_cmd_blocked", cmd_ready, 1'b0);
      tick();
      clr = 1'b0;
      cmd_valid = 1'b0;
      check("t5_rsp_flushed", rsp_valid, 1'b0);
      check("t5_init_done_low", init_done, 1'b0);
      check("t5_ram_we_low", ram_we, 1'b0);
      check_sweep("t5");
      send_cmd(1'b0, 4'd9, 8'h00);
      get_rsp("t5_cleared_word", 4'd9, 8'h00);

      // T6: asynchronous reset during back-to-back writes
      cmd_valid = 1'b1; cmd_we = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cmd_addr = AW'(i + 2); cmd_wdata = DW'(8'hA0 + i);
         tick();
      end
      check("t6_pre_we", ram_we, 1'b1);
      check("t6_pre_addr", ram_addr, 7);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("t6_async");
      cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_vals("t6_held");
      rst_n = 1'b1;
      check_sweep("t6");
      send_cmd(1'b0, 4'd4, 8'h00);
      get_rsp("t6_cleared_word", 4'd4, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
